demux1a4_ochobits_cond: RTL and testbench
=========================================

// Module: demux1a4_ochobits_cond
// PURPOSE
//  Receive-side counterpart of the 4-lane -> 1-lane byte mux layer: rebuilds four 8-bit lanes
//  from one serialized byte stream with valid. Bytes are taken in lane order 0,1,2,3 and
//  released together as one aligned 4-lane group. Sits at the receive end of the link,
//  before lane-level consumers. Gaps (valid_in=0) are tolerated at any point.
// PARAMETERS
//  WIDTH  8  bits per lane/byte
// PORTS
//  clk             in   1        rising-edge clock; single clock domain
//  reset           in   1        synchronous, active-high reset
//  valid_in        in   1        data_in carries a byte this cycle
//  data_in         in   WIDTH    serialized byte stream
//  flush           in   1        emit the partial group now; re-align to lane 0
//  validout0..3    out  1 each   lane n of the emitted group is valid; 1-cycle pulse
//  dataout0..3     out  WIDTH    lane n data; held between emissions
//  fill_level      out  2        bytes held in the current partial group (0..3)
// BEHAVIOUR
//  - All logic is on the rising edge of clk. Reset is sampled synchronously and has priority
//    over every other input.
//  - Reset: validout0..3=0, dataout0..3=0, fill_level=0, hold registers=0, lane pointer=0.
//    Reset asserted mid-group discards the partial group and emits nothing.
//  - State = 2-bit lane pointer ptr (FILL0..FILL3). fill_level = ptr.
//  - valid_in=1, flush=0, ptr<3: hold[ptr] <= data_in; ptr <= ptr+1; no output valids.
//  - valid_in=1, flush=0, ptr=3 (group complete):
//      dataout0..2 <= hold0..2; dataout3 <= data_in; validout0..3 <= 1; ptr <= 0.
//      Latency: 1 cycle. The group is visible the cycle after the 4th byte is sampled.
//  - valid_in=0, flush=0: no state change; data_in is ignored; validouts return to 0.
//  - flush=1: the byte on data_in is accepted first, if valid_in=1. Then all filled lanes
//    0..k-1 are emitted: dataout of those lanes <= held bytes, validout of those lanes <= 1.
//    Unfilled lanes keep their old dataout and have validout=0. ptr <= 0.
//      flush with 0 bytes held and valid_in=0: nothing is emitted and ptr stays 0.
//      flush+valid_in at ptr=3: this is an ordinary full group (all four valids).
//  - Hold registers are not cleared by emission. Only reset clears them.
//  - validout* is high for exactly one cycle per emission, even with back-to-back groups.
//    With valid_in=1 continuously, one full group is emitted every 4 cycles.
//  - Lane pointer wraps 3 -> 0 only on completion, flush or reset. No other wrap exists.
//  - dataout* changes only in the cycle where the matching validout* is 1, or on reset.
// TESTING
//  1) reset=1 for 2 cycles, then 0 -> all outputs 0 and fill_level=0 on the first cycle
//     after reset.
//  2) valid_in=1 for 4 cycles with data 8'hA0,A1,A2,A3 -> one cycle later dataout0..3 =
//     A0..A3, validout0..3=1 for 1 cycle, fill_level=0.
//  3) Bytes 11,22 / gap 3 cycles / 33,44 -> one group 11,22,33,44 one cycle after 44,
//     with no valid pulse before that.
//  4) Bytes 55,66, then flush=1 with valid_in=0 -> dataout0=55, dataout1=66, validout0/1=1,
//     validout2/3=0, dataout2/3 unchanged. Then bytes 01..04 -> full group starting at lane 0.
//  5) Bytes 0x10..0x15 continuous, reset=1 on the 6th byte's cycle -> only group 10..13 is
//     emitted; 14 and 15 are discarded; the next 4 bytes form a fresh group at lane 0.
//  6) 16 continuous bytes 00..0F -> four groups on cycles 5,9,13,17, each validout pulse
//     1 cycle wide; check flush+valid_in at ptr=3 behaves the same as a normal completion.

Source files
------------

// File: rtl/demux1a4_ochobits_cond_if.sv
// demux1a4_ochobits_cond_if: byte-stream input and four-lane output bundle for the 1->4 lane demux.
//   master : valid_in, data_in, flush driven; validout0..3, dataout0..3, fill_level observed
//   slave  : valid_in, data_in, flush observed; validout0..3, dataout0..3, fill_level driven
interface demux1a4_ochobits_cond_if #(
    parameter int WIDTH = 8
);
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             flush;
    logic             validout0;
    logic             validout1;
    logic             validout2;
    logic             validout3;
    logic [WIDTH-1:0] dataout0;
    logic [WIDTH-1:0] dataout1;
    logic [WIDTH-1:0] dataout2;
    logic [WIDTH-1:0] dataout3;
    logic [1:0]       fill_level;

    modport master (
        output valid_in, data_in, flush,
        input  validout0, validout1, validout2, validout3,
        input  dataout0, dataout1, dataout2, dataout3, fill_level
    );

    modport slave (
        input  valid_in, data_in, flush,
        output validout0, validout1, validout2, validout3,
        output dataout0, dataout1, dataout2, dataout3, fill_level
    );
endinterface

// File: rtl/demux1a4_ochobits_cond.sv
// demux1a4_ochobits_cond: rebuilds four byte lanes from one serialized byte stream.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, highest priority
//   bus   : slave side of demux1a4_ochobits_cond_if (valid_in/data_in/flush in,
//           validout0..3 / dataout0..3 / fill_level out)
module demux1a4_ochobits_cond #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    demux1a4_ochobits_cond_if.slave       bus
);
    logic [1:0]            ptr_q, ptr_d;
    logic [2:0][WIDTH-1:0] hold_q, hold_d;
    logic [3:0]            vld_q, vld_d;
    logic [3:0][WIDTH-1:0] dat_q, dat_d;
    logic [3:0][WIDTH-1:0] lane;
    logic [2:0]            cnt;
    logic                  take;
    logic                  emit;

    always_comb begin
        take   = bus.valid_in;
        // bytes in the group once this cycle's byte (if any) is accepted
        cnt    = {1'b0, ptr_q} + {2'b00, take};
        emit   = bus.flush || (take && ptr_q == 2'd3);
        ptr_d  = emit ? 2'd0 : ptr_q + {1'b0, take};
        hold_d = hold_q;
        lane   = '0;
        for (int l = 0; l < 3; l++) begin
            hold_d[l] = (take && ptr_q == 2'(l)) ? bus.data_in : hold_q[l];
            lane[l]   = (ptr_q == 2'(l)) ? bus.data_in : hold_q[l];
        end
        lane[3] = bus.data_in;
        for (int l = 0; l < 4; l++) begin
            vld_d[l] = emit && (3'(l) < cnt);
            dat_d[l] = vld_d[l] ? lane[l] : dat_q[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            hold_q <= '0;
            vld_q  <= '0;
            dat_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            vld_q  <= vld_d;
            dat_q  <= dat_d;
        end
    end

    assign bus.validout0  = vld_q[0];
    assign bus.validout1  = vld_q[1];
    assign bus.validout2  = vld_q[2];
    assign bus.validout3  = vld_q[3];
    assign bus.dataout0   = dat_q[0];
    assign bus.dataout1   = dat_q[1];
    assign bus.dataout2   = dat_q[2];
    assign bus.dataout3   = dat_q[3];
    assign bus.fill_level = ptr_q;
endmodule

// File: tb/tb_demux1a4_ochobits_cond.sv
// tb_demux1a4_ochobits_cond: directed and random stimulus checked against a queue-based model.
module tb_demux1a4_ochobits_cond;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] q[$];
    logic       exp_v[4];
    logic [7:0] exp_d[4];

    demux1a4_ochobits_cond_if #(.WIDTH(8)) bus ();

    demux1a4_ochobits_cond #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        logic       ov[4];
        logic [7:0] od[4];
        @(negedge clk);
        reset        = r;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.flush    = f;
        @(posedge clk);
        if (r) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                exp_v[i] = 1'b0;
                exp_d[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) exp_v[i] = 1'b0;
            if (v) q.push_back(d);
            if (q.size() == 4 || f) begin
                for (int i = 0; i < q.size(); i++) begin
                    exp_v[i] = 1'b1;
                    exp_d[i] = q[i];
                end
                q.delete();
            end
        end
        #1;
        ov = '{bus.validout0, bus.validout1, bus.validout2, bus.validout3};
        od = '{bus.dataout0, bus.dataout1, bus.dataout2, bus.dataout3};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("validout%0d", i), 32'(ov[i]), 32'(exp_v[i]));
            chk($sformatf("dataout%0d", i), 32'(od[i]), 32'(exp_d[i]));
        end
        chk("fill_level", 32'(bus.fill_level), 32'(q.size()));
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        bus.flush    = 1'b0;
        // reset for two cycles, then idle
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        // single full group
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0);
        step(0, 8'h00, 0, 0);
        // group with a gap in the middle
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        repeat (3) step(0, 8'hEE, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(0, 8'h00, 0, 0);
        // partial flush, then re-aligned group
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        step(0, 8'h00, 1, 0);
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
        // flush with nothing held
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        // reset mid-group discards partial bytes
        for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0);
        step(1, 8'h15, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'h70 + 8'(i), 0, 0);
        // back-to-back groups, then flush+valid at the last lane
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0);
        step(1, 8'hC3, 1, 0);
        step(0, 8'h00, 0, 0);
        // flush+valid at partial fill
        step(1, 8'hD0, 0, 0);
        step(1, 8'hD1, 1, 0);
        step(0, 8'h00, 0, 0);
        // random traffic
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
